// File: rtl/reg_status_if.sv
// Issue / commit / regfile-write bundle for the register status controller.
// The slave modport is the controller's view; the master modport is the core's side.
interface reg_status_if #(
  parameter int TAG_W = 3
);
  logic             issueValid;
  logic             issueRdWrite;
  logic [4:0]       issueRd;
  logic [TAG_W-1:0] issueTag;
  logic [4:0]       issueRs1;
  logic [4:0]       issueRs2;
  logic             issueStall;
  logic             rs1Busy;
  logic             rs2Busy;
  logic [TAG_W-1:0] rs1Tag;
  logic [TAG_W-1:0] rs2Tag;
  logic             commitValid;
  logic             commitRdWrite;
  logic [4:0]       commitRd;
  logic [TAG_W-1:0] commitTag;
  logic [31:0]      commitData;
  logic             flush;
  logic             rfWriteEnable;
  logic [4:0]       rfWriteIndex;
  logic [31:0]      rfWriteData;
  logic [TAG_W:0]   inflight;

  modport slave (
    input  issueValid, issueRdWrite, issueRd, issueTag, issueRs1, issueRs2,
    input  commitValid, commitRdWrite, commitRd, commitTag, commitData, flush,
    output issueStall, rs1Busy, rs2Busy, rs1Tag, rs2Tag,
    output rfWriteEnable, rfWriteIndex, rfWriteData, inflight
  );

  modport master (
    output issueValid, issueRdWrite, issueRd, issueTag, issueRs1, issueRs2,
    output commitValid, commitRdWrite, commitRd, commitTag, commitData, flush,
    input  issueStall, rs1Busy, rs2Busy, rs1Tag, rs2Tag,
    input  rfWriteEnable, rfWriteIndex, rfWriteData, inflight
  );
endinterface

// File: rtl/reg_status_ctrl.sv
// Tracks pending writers per architectural register, sequences the regfile
// write port from ROB commits, and stalls issue when every ROB tag is in use.
module reg_status_ctrl #(
  parameter int TAG_W = 3,
  parameter int NREG  = 32
) (
  input logic         clk,
  input logic         rst,
  reg_status_if.slave rsc_if
);
  localparam logic [TAG_W:0] DEPTH = {1'b1, {TAG_W{1'b0}}};
  localparam logic [TAG_W:0] ONE   = {{TAG_W{1'b0}}, 1'b1};

  logic [NREG-1:0]  busy_q, busy_d;
  logic [TAG_W-1:0] tag_q [NREG];
  logic [TAG_W-1:0] tag_d [NREG];
  logic [TAG_W:0]   inflight_q, inflight_d;
  logic             rf_we_q;
  logic [4:0]       rf_idx_q;
  logic [31:0]      rf_data_q;

  logic issue_acc;
  logic commit_hit;
  logic rf_wr;
  logic [TAG_W:0] lk1, lk2;

  // Source lookup: a same-cycle commit of the current owner reads as not busy.
  function automatic logic [TAG_W:0] lookup(
    input logic [4:0]       rs,
    input logic             b,
    input logic [TAG_W-1:0] t,
    input logic             cv,
    input logic             cw,
    input logic [4:0]       crd,
    input logic [TAG_W-1:0] ctag
  );
    lookup = '0;
    if (rs != 5'd0 && b && !(cv && cw && crd == rs && ctag == t))
      lookup = {1'b1, t};
  endfunction

  assign rsc_if.issueStall = (inflight_q == DEPTH);
  assign issue_acc  = rsc_if.issueValid && !rsc_if.issueStall && !rsc_if.flush;
  assign commit_hit = rsc_if.commitValid && rsc_if.commitRdWrite && rsc_if.commitRd != 5'd0 &&
                      busy_q[rsc_if.commitRd] && tag_q[rsc_if.commitRd] == rsc_if.commitTag;
  assign rf_wr      = rsc_if.commitValid && rsc_if.commitRdWrite && rsc_if.commitRd != 5'd0;

  assign lk1 = lookup(rsc_if.issueRs1, busy_q[rsc_if.issueRs1], tag_q[rsc_if.issueRs1],
                      rsc_if.commitValid, rsc_if.commitRdWrite, rsc_if.commitRd, rsc_if.commitTag);
  assign lk2 = lookup(rsc_if.issueRs2, busy_q[rsc_if.issueRs2], tag_q[rsc_if.issueRs2],
                      rsc_if.commitValid, rsc_if.commitRdWrite, rsc_if.commitRd, rsc_if.commitTag);

  assign rsc_if.rs1Busy = lk1[TAG_W];
  assign rsc_if.rs1Tag  = lk1[TAG_W-1:0];
  assign rsc_if.rs2Busy = lk2[TAG_W];
  assign rsc_if.rs2Tag  = lk2[TAG_W-1:0];

  // Issue is applied after commit so a same-cycle re-issue keeps the register busy.
  always_comb begin
    busy_d = busy_q;
    tag_d  = tag_q;
    if (commit_hit)
      busy_d[rsc_if.commitRd] = 1'b0;
    if (issue_acc && rsc_if.issueRdWrite && rsc_if.issueRd != 5'd0) begin
      busy_d[rsc_if.issueRd] = 1'b1;
      tag_d[rsc_if.issueRd]  = rsc_if.issueTag;
    end
    if (rsc_if.flush)
      busy_d = '0;
    busy_d[0] = 1'b0;
  end

  always_comb begin
    inflight_d = inflight_q;
    if (rsc_if.flush)
      inflight_d = '0;
    else if (issue_acc && !rsc_if.commitValid)
      inflight_d = inflight_q + ONE;
    else if (!issue_acc && rsc_if.commitValid && inflight_q != '0)
      inflight_d = inflight_q - ONE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q     <= '0;
      tag_q      <= '{default: '0};
      inflight_q <= '0;
      rf_we_q    <= 1'b0;
      rf_idx_q   <= '0;
      rf_data_q  <= '0;
    end else begin
      busy_q     <= busy_d;
      tag_q      <= tag_d;
      inflight_q <= inflight_d;
      rf_we_q    <= rf_wr;
      if (rf_wr) begin
        rf_idx_q  <= rsc_if.commitRd;
        rf_data_q <= rsc_if.commitData;
      end
    end
  end

  assign rsc_if.rfWriteEnable = rf_we_q;
  assign rsc_if.rfWriteIndex  = rf_idx_q;
  assign rsc_if.rfWriteData   = rf_data_q;
  assign rsc_if.inflight      = inflight_q;
endmodule

// File: tb/tb_reg_status_ctrl.sv
// Directed bench for reg_status_ctrl: one task per scenario, inline checks
// against hand-computed values, single summary line at the end.
module tb_reg_status_ctrl;
  localparam int TAG_W = 3;

  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;

  reg_status_if #(.TAG_W(TAG_W)) bus ();

  reg_status_ctrl #(.TAG_W(TAG_W), .NREG(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .rsc_if (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    bus.issueValid    = 1'b0;
    bus.issueRdWrite  = 1'b0;
    bus.issueRd       = '0;
    bus.issueTag      = '0;
    bus.issueRs1      = '0;
    bus.issueRs2      = '0;
    bus.commitValid   = 1'b0;
    bus.commitRdWrite = 1'b0;
    bus.commitRd      = '0;
    bus.commitTag     = '0;
    bus.commitData    = '0;
    bus.flush         = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_issue(input logic [4:0] rd, input logic wr, input logic [TAG_W-1:0] tag);
    bus.issueValid   = 1'b1;
    bus.issueRdWrite = wr;
    bus.issueRd      = rd;
    bus.issueTag     = tag;
  endtask

  task automatic drive_commit(input logic [4:0] rd, input logic wr, input logic [TAG_W-1:0] tag,
                              input logic [31:0] data);
    bus.commitValid   = 1'b1;
    bus.commitRdWrite = wr;
    bus.commitRd      = rd;
    bus.commitTag     = tag;
    bus.commitData    = data;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    #12;
    tests_run++;
    if (bus.rfWriteEnable !== 1'b0 || bus.rfWriteIndex !== 5'd0 || bus.rfWriteData !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_rf: we=%0b idx=%0d data=%h expected 0/0/0", bus.rfWriteEnable, bus.rfWriteIndex, bus.rfWriteData);
    end
    tests_run++;
    if (bus.inflight !== 4'd0 || bus.issueStall !== 1'b0 || bus.rs1Busy !== 1'b0 || bus.rs1Tag !== 3'd0) begin
      tests_failed++;
      $display("FAIL reset_state: inflight=%0d stall=%0b rs1Busy=%0b rs1Tag=%0d expected 0", bus.inflight, bus.issueStall, bus.rs1Busy, bus.rs1Tag);
    end
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_issue_commit();
    idle();
    drive_issue(5'd5, 1'b1, 3'd2);
    bus.issueRs1 = 5'd5;
    #1;
    tests_run++;
    if (bus.rs1Busy !== 1'b0) begin
      tests_failed++; $display("FAIL own_rd_lookup: rs1Busy=%0b expected 0", bus.rs1Busy);
    end
    tick();
    idle();
    bus.issueRs1 = 5'd5;
    #1;
    tests_run++;
    if (bus.rs1Busy !== 1'b1 || bus.rs1Tag !== 3'd2 || bus.inflight !== 4'd1) begin
      tests_failed++; $display("FAIL issue_busy: busy=%0b tag=%0d inflight=%0d expected 1/2/1", bus.rs1Busy, bus.rs1Tag, bus.inflight);
    end
    drive_commit(5'd5, 1'b1, 3'd2, 32'h1234);
    #1;
    tests_run++;
    if (bus.rs1Busy !== 1'b0 || bus.rs1Tag !== 3'd0) begin
      tests_failed++; $display("FAIL commit_bypass: busy=%0b tag=%0d expected 0/0", bus.rs1Busy, bus.rs1Tag);
    end
    tick();
    idle();
    bus.issueRs1 = 5'd5;
    #1;
    tests_run++;
    if (bus.rfWriteEnable !== 1'b1 || bus.rfWriteIndex !== 5'd5 || bus.rfWriteData !== 32'h1234) begin
      tests_failed++; $display("FAIL rf_write: we=%0b idx=%0d data=%h expected 1/5/1234", bus.rfWriteEnable, bus.rfWriteIndex, bus.rfWriteData);
    end
    tests_run++;
    if (bus.rs1Busy !== 1'b0 || bus.inflight !== 4'd0) begin
      tests_failed++; $display("FAIL commit_cleared: busy=%0b inflight=%0d expected 0/0", bus.rs1Busy, bus.inflight);
    end
    tick();
    tests_run++;
    if (bus.rfWriteEnable !== 1'b0 || bus.rfWriteIndex !== 5'd5) begin
      tests_failed++; $display("FAIL rf_pulse_end: we=%0b idx=%0d expected 0/5", bus.rfWriteEnable, bus.rfWriteIndex);
    end
  endtask

  task automatic test_tag_mismatch();
    idle();
    drive_issue(5'd7, 1'b1, 3'd1);
    tick();
    drive_issue(5'd7, 1'b1, 3'd4);
    tick();
    idle();
    drive_commit(5'd7, 1'b1, 3'd1, 32'h00AA);
    bus.issueRs1 = 5'd7;
    #1;
    tests_run++;
    if (bus.rs1Busy !== 1'b1 || bus.rs1Tag !== 3'd4) begin
      tests_failed++; $display("FAIL stale_bypass: busy=%0b tag=%0d expected 1/4", bus.rs1Busy, bus.rs1Tag);
    end
    tick();
    idle();
    bus.issueRs1 = 5'd7;
    #1;
    tests_run++;
    if (bus.rs1Busy !== 1'b1 || bus.rs1Tag !== 3'd4 || bus.rfWriteEnable !== 1'b1 || bus.rfWriteIndex !== 5'd7 || bus.inflight !== 4'd1) begin
      tests_failed++;
      $display("FAIL stale_commit: busy=%0b tag=%0d we=%0b idx=%0d inflight=%0d expected 1/4/1/7/1", bus.rs1Busy, bus.rs1Tag, bus.rfWriteEnable, bus.rfWriteIndex, bus.inflight);
    end
    drive_commit(5'd7, 1'b1, 3'd4, 32'h00BB);
    tick();
    idle();
    bus.issueRs1 = 5'd7;
    #1;
    tests_run++;
    if (bus.rs1Busy !== 1'b0 || bus.inflight !== 4'd0 || bus.rfWriteData !== 32'h00BB) begin
      tests_failed++; $display("FAIL owner_commit: busy=%0b inflight=%0d data=%h expected 0/0/bb", bus.rs1Busy, bus.inflight, bus.rfWriteData);
    end
  endtask

  task automatic test_full_stall();
    idle();
    for (int i = 0; i < 8; i++) begin
      drive_issue(5'd20, 1'b0, 3'(i));
      tick();
    end
    tests_run++;
    if (bus.inflight !== 4'd8 || bus.issueStall !== 1'b1) begin
      tests_failed++; $display("FAIL full: inflight=%0d stall=%0b expected 8/1", bus.inflight, bus.issueStall);
    end
    drive_issue(5'd12, 1'b1, 3'd0);
    tick();
    idle();
    bus.issueRs1 = 5'd12;
    #1;
    tests_run++;
    if (bus.inflight !== 4'd8 || bus.rs1Busy !== 1'b0) begin
      tests_failed++; $display("FAIL stalled_issue: inflight=%0d rs1Busy=%0b expected 8/0", bus.inflight, bus.rs1Busy);
    end
    drive_commit(5'd0, 1'b0, 3'd0, 32'd0);
    tick();
    idle();
    tests_run++;
    if (bus.inflight !== 4'd7 || bus.issueStall !== 1'b0) begin
      tests_failed++; $display("FAIL unstall: inflight=%0d stall=%0b expected 7/0", bus.inflight, bus.issueStall);
    end
    drive_issue(5'd20, 1'b0, 3'd0);
    drive_commit(5'd0, 1'b0, 3'd1, 32'd0);
    tick();
    idle();
    tests_run++;
    if (bus.inflight !== 4'd7) begin
      tests_failed++; $display("FAIL issue_and_commit: inflight=%0d expected 7", bus.inflight);
    end
    for (int i = 0; i < 8; i++) begin
      drive_commit(5'd0, 1'b0, 3'd0, 32'd0);
      tick();
    end
    idle();
    tests_run++;
    if (bus.inflight !== 4'd0) begin
      tests_failed++; $display("FAIL no_underflow: inflight=%0d expected 0", bus.inflight);
    end
  endtask

  task automatic test_x0();
    idle();
    drive_issue(5'd0, 1'b1, 3'd3);
    tick();
    idle();
    #1;
    tests_run++;
    if (bus.rs1Busy !== 1'b0 || bus.rs2Busy !== 1'b0 || bus.rs1Tag !== 3'd0 || bus.inflight !== 4'd1) begin
      tests_failed++; $display("FAIL x0_issue: rs1Busy=%0b rs2Busy=%0b inflight=%0d expected 0/0/1", bus.rs1Busy, bus.rs2Busy, bus.inflight);
    end
    drive_commit(5'd0, 1'b1, 3'd3, 32'hFFFF);
    tick();
    idle();
    tests_run++;
    if (bus.rfWriteEnable !== 1'b0 || bus.inflight !== 4'd0) begin
      tests_failed++; $display("FAIL x0_commit: we=%0b inflight=%0d expected 0/0", bus.rfWriteEnable, bus.inflight);
    end
  endtask

  task automatic test_back_to_back();
    idle();
    drive_issue(5'd1, 1'b1, 3'd0);
    tick();
    drive_issue(5'd2, 1'b1, 3'd1);
    tick();
    idle();
    drive_commit(5'd1, 1'b1, 3'd0, 32'h11);
    tick();
    drive_commit(5'd2, 1'b1, 3'd1, 32'h22);
    #1;
    tests_run++;
    if (bus.rfWriteEnable !== 1'b1 || bus.rfWriteIndex !== 5'd1 || bus.rfWriteData !== 32'h11) begin
      tests_failed++; $display("FAIL b2b_first: we=%0b idx=%0d data=%h expected 1/1/11", bus.rfWriteEnable, bus.rfWriteIndex, bus.rfWriteData);
    end
    tick();
    idle();
    tests_run++;
    if (bus.rfWriteEnable !== 1'b1 || bus.rfWriteIndex !== 5'd2 || bus.rfWriteData !== 32'h22 || bus.inflight !== 4'd0) begin
      tests_failed++; $display("FAIL b2b_second: we=%0b idx=%0d data=%h inflight=%0d expected 1/2/22/0", bus.rfWriteEnable, bus.rfWriteIndex, bus.rfWriteData, bus.inflight);
    end
    drive_issue(5'd13, 1'b1, 3'd2);
    tick();
    drive_issue(5'd13, 1'b1, 3'd3);
    drive_commit(5'd13, 1'b1, 3'd2, 32'h13);
    tick();
    idle();
    bus.issueRs2 = 5'd13;
    #1;
    tests_run++;
    if (bus.rs2Busy !== 1'b1 || bus.rs2Tag !== 3'd3 || bus.inflight !== 4'd1) begin
      tests_failed++; $display("FAIL same_rd_issue_wins: busy=%0b tag=%0d inflight=%0d expected 1/3/1", bus.rs2Busy, bus.rs2Tag, bus.inflight);
    end
    drive_commit(5'd13, 1'b1, 3'd3, 32'h14);
    tick();
    idle();
  endtask

  task automatic test_flush();
    idle();
    drive_issue(5'd3, 1'b1, 3'd0);
    tick();
    drive_issue(5'd4, 1'b1, 3'd1);
    tick();
    drive_issue(5'd6, 1'b1, 3'd2);
    tick();
    idle();
    #1;
    tests_run++;
    if (bus.inflight !== 4'd3) begin
      tests_failed++; $display("FAIL pre_flush: inflight=%0d expected 3", bus.inflight);
    end
    drive_issue(5'd9, 1'b1, 3'd5);
    drive_commit(5'd3, 1'b1, 3'd0, 32'h3333);
    bus.flush = 1'b1;
    tick();
    idle();
    bus.issueRs1 = 5'd3;
    bus.issueRs2 = 5'd9;
    #1;
    tests_run++;
    if (bus.rs1Busy !== 1'b0 || bus.rs2Busy !== 1'b0 || bus.inflight !== 4'd0) begin
      tests_failed++; $display("FAIL flush_state: rs3=%0b rs9=%0b inflight=%0d expected 0/0/0", bus.rs1Busy, bus.rs2Busy, bus.inflight);
    end
    bus.issueRs1 = 5'd4;
    bus.issueRs2 = 5'd6;
    #1;
    tests_run++;
    if (bus.rs1Busy !== 1'b0 || bus.rs2Busy !== 1'b0) begin
      tests_failed++; $display("FAIL flush_others: rs4=%0b rs6=%0b expected 0/0", bus.rs1Busy, bus.rs2Busy);
    end
    tests_run++;
    if (bus.rfWriteEnable !== 1'b1 || bus.rfWriteIndex !== 5'd3 || bus.rfWriteData !== 32'h3333) begin
      tests_failed++; $display("FAIL flush_rf: we=%0b idx=%0d data=%h expected 1/3/3333", bus.rfWriteEnable, bus.rfWriteIndex, bus.rfWriteData);
    end
    tick();
  endtask

  task automatic test_async_reset();
    idle();
    drive_issue(5'd8, 1'b1, 3'd6);
    tick();
    drive_issue(5'd11, 1'b1, 3'd7);
    drive_commit(5'd8, 1'b1, 3'd6, 32'hCAFE);
    tick();
    idle();
    bus.issueRs2 = 5'd11;
    #1;
    tests_run++;
    if (bus.rs2Busy !== 1'b1 || bus.rfWriteEnable !== 1'b1 || bus.inflight !== 4'd1) begin
      tests_failed++; $display("FAIL pre_reset: busy=%0b we=%0b inflight=%0d expected 1/1/1", bus.rs2Busy, bus.rfWriteEnable, bus.inflight);
    end
    #1 rst = 1'b1;
    #1;
    tests_run++;
    if (bus.rs2Busy !== 1'b0 || bus.rfWriteEnable !== 1'b0 || bus.rfWriteIndex !== 5'd0 || bus.rfWriteData !== 32'd0 ||
        bus.inflight !== 4'd0 || bus.issueStall !== 1'b0) begin
      tests_failed++;
      $display("FAIL async_reset: busy=%0b we=%0b idx=%0d data=%h inflight=%0d stall=%0b expected all 0", bus.rs2Busy, bus.rfWriteEnable, bus.rfWriteIndex, bus.rfWriteData, bus.inflight, bus.issueStall);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    drive_issue(5'd5, 1'b1, 3'd1);
    tick();
    idle();
    bus.issueRs1 = 5'd5;
    bus.issueRs2 = 5'd11;
    #1;
    tests_run++;
    if (bus.inflight !== 4'd1 || bus.rs1Busy !== 1'b1 || bus.rs1Tag !== 3'd1 || bus.rs2Busy !== 1'b0) begin
      tests_failed++; $display("FAIL post_reset: inflight=%0d rs5=%0b tag=%0d rs11=%0b expected 1/1/1/0", bus.inflight, bus.rs1Busy, bus.rs1Tag, bus.rs2Busy);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst          = 1'b1;
    test_reset();
    test_issue_commit();
    test_tag_mismatch();
    test_full_stall();
    test_x0();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
